// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an 8-digit hex
// 7-segment display with an active-low segment bus and digit enables.
// Writes land in a shadow register and are committed only at the end of a
// frame, so one frame never mixes old and new digits.
// Optional feature: define SEG_LZ_SUPPRESS_EN to blank leading zeros
// (digit 0 is never suppressed).
module seg_scan_ctrl #(
    parameter int CLK_DIV = 1000,
    parameter int DEAD    = 2,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_mask,
    output logic [7:0]  seg_o,
    output logic [7:0]  an_o,
    output logic        frame_o
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;

    logic [31:0]      active_data;
    logic [7:0]       active_mask;
    logic [31:0]      shadow_data;
    logic [7:0]       shadow_mask;
    logic             pending;

    logic             blank_last;
    logic             drive_last;
    logic             commit;
    logic             accept;
    logic [3:0]       cur_nib;
    logic [7:0]       suppress;
    logic             dig_en;

    // Hex nibble to active-high segment pattern {a,b,c,d,e,f,g,dp}; dp stays off.
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0:    pat = 8'hFC;
            4'h1:    pat = 8'h60;
            4'h2:    pat = 8'hDA;
            4'h3:    pat = 8'hF2;
            4'h4:    pat = 8'h66;
            4'h5:    pat = 8'hB6;
            4'h6:    pat = 8'hBE;
            4'h7:    pat = 8'hE0;
            4'h8:    pat = 8'hFE;
            4'h9:    pat = 8'hF6;
            4'hA:    pat = 8'hEE;
            4'hB:    pat = 8'h3E;
            4'hC:    pat = 8'h9C;
            4'hD:    pat = 8'h7A;
            4'hE:    pat = 8'h9E;
            default: pat = 8'h8E;
        endcase
        return pat;
    endfunction

`ifdef SEG_LZ_SUPPRESS_EN
    // Bit k set when nibbles k..7 are all zero; bit 0 is never set so a zero
    // value still shows a single "0".
    function automatic logic [7:0] lz_mask(input logic [31:0] d);
        logic [7:0] m;
        logic       zero_run;
        m        = 8'h00;
        zero_run = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            zero_run = zero_run & (d[4*k +: 4] == 4'h0);
            m[k]     = zero_run;
        end
        return m;
    endfunction

    assign suppress = lz_mask(active_data);
`else
    assign suppress = 8'h00;
`endif

    assign blank_last = (state == ST_BLANK) && (cnt == DEAD_LAST);
    assign drive_last = (state == ST_DRIVE) && (cnt == DRIVE_LAST);
    assign commit     = drive_last && (idx == 3'd7) && pending;
    assign accept     = wr_valid && !pending;
    assign wr_ready   = ~pending;
    assign cur_nib    = active_data[{idx, 2'b00} +: 4];
    assign dig_en     = active_mask[idx] & ~suppress[idx];

    // Scan FSM: outputs are registered from the current state/counter, so the
    // pins show a slot one clock after the state registers enter it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_BLANK;
            cnt     <= '0;
            idx     <= 3'd0;
            seg_o   <= 8'hFF;
            an_o    <= 8'hFF;
            frame_o <= 1'b0;
        end else begin
            frame_o <= (state == ST_BLANK) && (cnt == '0) && (idx == 3'd0);
            if ((state == ST_DRIVE) && dig_en) begin
                an_o  <= ~(8'b1 << idx);
                seg_o <= ~seg_decode(cur_nib);
            end else begin
                an_o  <= 8'hFF;
                seg_o <= 8'hFF;
            end
            case (state)
                ST_BLANK: begin
                    if (blank_last) begin
                        state <= ST_DRIVE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (drive_last) begin
                        state <= ST_BLANK;
                        cnt   <= '0;
                        idx   <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Write handshake and frame-boundary commit of shadow into active value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= 1'b0;
            active_data <= 32'h0;
            active_mask <= 8'h00;
        end else if (accept) begin
            pending <= 1'b1;
        end else if (commit) begin
            pending     <= 1'b0;
            active_data <= shadow_data;
            active_mask <= shadow_mask;
        end
    end

    // Shadow holds the most recently accepted write; it is only visible
    // after a commit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            shadow_data <= wr_data;
            shadow_mask <= wr_mask;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with CLK_DIV=4, DEAD=1 (40-cycle frame).
// A reference model predicts each output cycle from its position in the
// frame and from the committed value; predictions are queued per clock and
// popped when the DUT outputs for that clock are sampled.
module tb_seg_scan_ctrl;

    localparam int CLK_DIV = 4;
    localparam int DEAD    = 1;
    localparam int SLOT    = CLK_DIV + DEAD;
    localparam int PER     = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic [7:0]  wr_mask = 8'h00;
    logic        wr_ready;
    logic [7:0]  seg_o;
    logic [7:0]  an_o;
    logic        frame_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int          k;
    logic [31:0] m_act_d;
    logic [7:0]  m_act_m;
    logic [31:0] m_sh_d;
    logic [7:0]  m_sh_m;
    logic        m_pend;
    logic        m_acc;
    logic [17:0] sb[$];

    logic [7:0] seg_tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    seg_scan_ctrl #(
        .CLK_DIV(CLK_DIV),
        .DEAD   (DEAD),
        .CNT_W  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data (wr_data),
        .wr_mask (wr_mask),
        .seg_o   (seg_o),
        .an_o    (an_o),
        .frame_o (frame_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached got=timeout want=finish");
        $fatal(1);
    end

    // Expected {an, seg, frame, ready} for output position pos; the ready bit
    // is filled in by step().
    function automatic logic [17:0] expect_out(input int pos);
        int         slot;
        int         dig;
        logic       en;
        logic [7:0] an;
        logic [7:0] seg;
        slot = pos % SLOT;
        dig  = (pos / SLOT) % 8;
        an   = 8'hFF;
        seg  = 8'hFF;
        en   = 1'b0;
        if (slot >= DEAD) begin
            en = m_act_m[dig];
`ifdef SEG_LZ_SUPPRESS_EN
            if (dig != 0 && (m_act_d >> (4 * dig)) == 32'd0) en = 1'b0;
`endif
            if (en) begin
                an  = ~(8'h01 << dig);
                seg = ~seg_tbl[m_act_d[4*dig +: 4]];
            end
        end
        return {an, seg, ((pos % PER) == 0), 1'b0};
    endfunction

    // Advance one clock: predict this edge's outputs, update the model's
    // handshake/commit state, queue the prediction, then move to the sample point.
    task automatic step();
        logic [17:0] e;
        @(posedge clk);
        e     = expect_out(k);
        m_acc = 1'b0;
        if (wr_valid && !m_pend) begin
            m_sh_d = wr_data;
            m_sh_m = wr_mask;
            m_pend = 1'b1;
            m_acc  = 1'b1;
        end else if (m_pend && (k % PER) == PER - 1) begin
            m_act_d = m_sh_d;
            m_act_m = m_sh_m;
            m_pend  = 1'b0;
        end
        e[0] = ~m_pend;
        sb.push_back(e);
        k++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        k       = 0;
        m_act_d = 32'h0;
        m_act_m = 8'h00;
        m_pend  = 1'b0;
        m_acc   = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [17:0] exp;
        logic [17:0] obs;
        do_reset();
        obs = {an_o, seg_o, frame_o, wr_ready};
        n_tests++;
        if (obs !== {8'hFF, 8'hFF, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values got %h want %h", obs, {8'hFF, 8'hFF, 1'b0, 1'b1});
        end
        rst = 1'b0;
        model_reset();
        repeat (2 * PER) begin
            step();
            exp = sb.pop_front();
            obs = {an_o, seg_o, frame_o, wr_ready};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL idle_sb pos=%0d got %h want %h", k - 1, obs, exp);
            end
        end
    endtask

    task automatic test_write_basic();
        logic [17:0] exp;
        logic [17:0] obs;
        int          ds;
        int          pos;
        wr_valid = 1'b1;
        wr_data  = 32'h0123_4567;
        wr_mask  = 8'hFF;
        step();
        wr_valid = 1'b0;
        ds  = ((k - 1) / PER + 1) * PER;
        exp = sb.pop_front();
        obs = {an_o, seg_o, frame_o, wr_ready};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL write_accept got %h want %h", obs, exp);
        end
        while (k < ds + PER) begin
            step();
            pos = k - 1;
            exp = sb.pop_front();
            obs = {an_o, seg_o, frame_o, wr_ready};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL write_sb pos=%0d got %h want %h", pos, obs, exp);
            end
            if (pos >= ds && an_o == 8'hFE) begin
                n_tests++;
                if (seg_o !== 8'h1F) begin
                    n_fail++;
                    $display("FAIL digit0_seg got %h want 1f", seg_o);
                end
            end
            if (pos >= ds && an_o == 8'h7F) begin
                n_tests++;
                if (seg_o !== 8'h03) begin
                    n_fail++;
                    $display("FAIL digit7_seg got %h want 03", seg_o);
                end
            end
        end
    endtask

    task automatic test_mask();
        logic [17:0] exp;
        logic [17:0] obs;
        int          ds;
        int          pos;
        wr_valid = 1'b1;
        wr_data  = 32'hFFFF_FFFF;
        wr_mask  = 8'h05;
        step();
        wr_valid = 1'b0;
        ds  = ((k - 1) / PER + 1) * PER;
        exp = sb.pop_front();
        obs = {an_o, seg_o, frame_o, wr_ready};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL mask_accept got %h want %h", obs, exp);
        end
        while (k < ds + PER) begin
            step();
            pos = k - 1;
            exp = sb.pop_front();
            obs = {an_o, seg_o, frame_o, wr_ready};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL mask_sb pos=%0d got %h want %h", pos, obs, exp);
            end
            if (pos >= ds && an_o != 8'hFF) begin
                n_tests++;
                if (!((an_o == 8'hFE || an_o == 8'hFB) && seg_o == 8'h71)) begin
                    n_fail++;
                    $display("FAIL mask_lit pos=%0d got an=%h seg=%h want an=fe/fb seg=71", pos, an_o, seg_o);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp;
        logic [17:0] obs;
        int          ds_a;
        int          pos;
        repeat (10) begin
            step();
            exp = sb.pop_front();
            obs = {an_o, seg_o, frame_o, wr_ready};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL b2b_idle pos=%0d got %h want %h", k - 1, obs, exp);
            end
        end
        wr_valid = 1'b1;
        wr_data  = 32'h1111_1111;
        wr_mask  = 8'hFF;
        step();
        ds_a = ((k - 1) / PER + 1) * PER;
        exp  = sb.pop_front();
        obs  = {an_o, seg_o, frame_o, wr_ready};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_accept_a got %h want %h", obs, exp);
        end
        wr_data = 32'h2222_2222;
        while (k < ds_a + 2 * PER) begin
            step();
            pos = k - 1;
            if (wr_valid && m_acc) wr_valid = 1'b0;
            exp = sb.pop_front();
            obs = {an_o, seg_o, frame_o, wr_ready};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL b2b_sb pos=%0d got %h want %h", pos, obs, exp);
            end
            if (pos >= ds_a && pos < ds_a + PER && an_o != 8'hFF) begin
                n_tests++;
                if (seg_o !== 8'h9F) begin
                    n_fail++;
                    $display("FAIL frame_a_seg pos=%0d got %h want 9f", pos, seg_o);
                end
            end
            if (pos >= ds_a + PER && an_o != 8'hFF) begin
                n_tests++;
                if (seg_o !== 8'h25) begin
                    n_fail++;
                    $display("FAIL frame_b_seg pos=%0d got %h want 25", pos, seg_o);
                end
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [17:0] exp;
        logic [17:0] obs;
        int          guard;
        wr_valid = 1'b1;
        wr_data  = 32'h89AB_CDEF;
        wr_mask  = 8'hFF;
        step();
        wr_valid = 1'b0;
        exp = sb.pop_front();
        obs = {an_o, seg_o, frame_o, wr_ready};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rstmid_accept got %h want %h", obs, exp);
        end
        guard = 0;
        while (((k - 1) % PER) != 17 && guard < 2 * PER) begin
            step();
            guard++;
            exp = sb.pop_front();
            obs = {an_o, seg_o, frame_o, wr_ready};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL rstmid_sb pos=%0d got %h want %h", k - 1, obs, exp);
            end
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        obs = {an_o, seg_o, frame_o, wr_ready};
        n_tests++;
        if (obs !== {8'hFF, 8'hFF, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_values got %h want %h", obs, {8'hFF, 8'hFF, 1'b0, 1'b1});
        end
        rst = 1'b0;
        model_reset();
        repeat (2 * PER) begin
            step();
            exp = sb.pop_front();
            obs = {an_o, seg_o, frame_o, wr_ready};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL rstmid_after pos=%0d got %h want %h", k - 1, obs, exp);
            end
            n_tests++;
            if (an_o !== 8'hFF) begin
                n_fail++;
                $display("FAIL rstmid_dark pos=%0d got an=%h want ff", k - 1, an_o);
            end
        end
    endtask

    task automatic test_zero_digits();
        logic [17:0] exp;
        logic [17:0] obs;
        logic [31:0] vals [2];
        int          ds;
        int          pos;
        vals[0] = 32'h0000_00A0;
        vals[1] = 32'h0000_0000;
        for (int v = 0; v < 2; v++) begin
            wr_valid = 1'b1;
            wr_data  = vals[v];
            wr_mask  = 8'hFF;
            step();
            wr_valid = 1'b0;
            ds  = ((k - 1) / PER + 1) * PER;
            exp = sb.pop_front();
            obs = {an_o, seg_o, frame_o, wr_ready};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL zero_accept v=%0d got %h want %h", v, obs, exp);
            end
            while (k < ds + PER) begin
                step();
                pos = k - 1;
                exp = sb.pop_front();
                obs = {an_o, seg_o, frame_o, wr_ready};
                n_tests++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL zero_sb v=%0d pos=%0d got %h want %h", v, pos, obs, exp);
                end
                if (pos >= ds && an_o != 8'hFF) begin
                    n_tests++;
`ifdef SEG_LZ_SUPPRESS_EN
                    if (!((an_o == 8'hFE && seg_o == 8'h03) ||
                          (v == 0 && an_o == 8'hFD && seg_o == 8'h11))) begin
`else
                    if (!((an_o == 8'hFD && v == 0) ? (seg_o == 8'h11) : (seg_o == 8'h03))) begin
`endif
                        n_fail++;
                        $display("FAIL zero_lit v=%0d pos=%0d got an=%h seg=%h", v, pos, an_o, seg_o);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_mask();
        test_back_to_back();
        test_reset_mid();
        test_zero_digits();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
